// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead slice: two-level lookahead carries, group P/G exported.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3,
  output logic       p,
  output logic       g
);

  logic [3:0] pb;
  logic [3:0] gb;
  logic       c1;
  logic       c2;

  assign pb = a ^ b;
  assign gb = a & b;

  // Every carry is a flat sum of products of g/p and cin, no chaining.
  assign c1 = gb[0] | (pb[0] & cin);
  assign c2 = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
  assign c3 = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
            | (pb[2] & pb[1] & pb[0] & cin);

  assign p = &pb;
  assign g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
           | (pb[3] & pb[2] & pb[1] & gb[0]);

  assign cout = g | (p & cin);
  assign s    = pb ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Sequencer that time-multiplexes one cla4_slice over WIDTH-bit operands,
// least-significant nibble first, between valid/ready source and sink.
module cla_seq_adder_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       dbg_state,
  output logic [1:0]       dbg_pg
);

  localparam int N  = WIDTH / NIBBLE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and valid holds until taken.
  state_t             state;
  logic [IW-1:0]      idx;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   sum_reg;
  logic               carry;

  logic [NIBBLE-1:0]  a_nib;
  logic [NIBBLE-1:0]  b_nib;
  logic [NIBBLE-1:0]  s_nib;
  logic               s_cout;
  logic               s_c3;
  logic               s_p;
  logic               s_g;
  logic [WIDTH-1:0]   sum_next;

  assign a_nib = a_reg[idx*NIBBLE +: NIBBLE];
  assign b_nib = b_reg[idx*NIBBLE +: NIBBLE];

  cla4_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .s    (s_nib),
    .cout (s_cout),
    .c3   (s_c3),
    .p    (s_p),
    .g    (s_g)
  );

  always_comb begin
    sum_next = sum_reg;
    sum_next[idx*NIBBLE +: NIBBLE] = s_nib;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= op_sub ? ~b : b;
            carry <= op_sub | cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_reg <= sum_next;
          carry   <= s_cout;
          if (idx == LAST) begin
            cout  <= s_cout;
            ovf   <= s_c3 ^ s_cout;
            zero  <= (sum_next == '0);
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset is folded into in_ready so it reads 0 for the whole reset pulse.
  assign in_ready  = (state == IDLE) & ~reset;
  assign out_valid = (state == DONE);
  assign sum       = sum_reg;
  assign dbg_state = state;
  assign dbg_pg    = {s_p, s_g};

endmodule
